// File: rtl/sr_pkg.sv
// Shared types and constants for the sr_ff command-side driver.
package sr_pkg;

    // Driver sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Error codes reported on err_code_o.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_DISTURB = 2'b11;

    // True when the q/qb pair is a legal encoding of the target value.
    function automatic logic fb_matches(input logic q, input logic qb, input logic tgt);
        return (q == tgt) && (qb == ~tgt);
    endfunction

endpackage

// File: rtl/sr_ff_driver_if.sv
// Request handshake between control logic and the sr_ff driver.
interface sr_ff_driver_if #(
    parameter int HOLD_W = 8
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_val_i;
    logic [HOLD_W-1:0] req_hold_i;

    // Control logic side: issues requests, observes ready.
    modport master (
        output req_valid_i,
        output req_val_i,
        output req_hold_i,
        input  req_ready_o
    );

    // Driver side: accepts requests, reports ready.
    modport slave (
        input  req_valid_i,
        input  req_val_i,
        input  req_hold_i,
        output req_ready_o
    );
endinterface

// File: rtl/sr_ff_driver.sv
// Converts set/clear requests into single-cycle S/R pulses for an sr_ff,
// verifies the q/qb feedback, holds the result and reports done or error.
// One down-counter serves both the WAIT timeout and the HOLD duration.
module sr_ff_driver
    import sr_pkg::*;
#(
    parameter int HOLD_W  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sr_ff_driver_if.slave        req,
    input  logic                 q_i,
    input  logic                 qb_i,
    output logic                 s_o,
    output logic                 r_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o
);

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (HOLD_W > TO_W) ? HOLD_W : TO_W;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_tgt;
    logic                w_tgt_nxt;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [1:0]          w_err_code_nxt;

    // Next-state, counter and latched-request logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tgt_nxt      = r_tgt;
        w_hold_nxt     = r_hold;
        w_err_code_nxt = err_code_o;
        case (r_state)
            ST_IDLE: begin
                if (req.req_valid_i) begin
                    w_tgt_nxt      = req.req_val_i;
                    w_hold_nxt     = req.req_hold_i;
                    w_err_code_nxt = ERR_NONE;
                    // Already at target: skip the pulse entirely.
                    if (fb_matches(q_i, qb_i, req.req_val_i)) begin
                        if (req.req_hold_i != '0) begin
                            w_state_nxt = ST_HOLD;
                            w_cnt_nxt   = CNT_W'(req.req_hold_i);
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_state_nxt = ST_DRIVE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = CNT_W'(TIMEOUT);
            end
            ST_WAIT: begin
                if (q_i == qb_i) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_ILLEGAL;
                end else if (q_i == r_tgt) begin
                    if (r_hold != '0) begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = CNT_W'(r_hold);
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if ((q_i != r_tgt) || (qb_i == q_i)) begin
                    w_state_nxt    = ST_ERR;
                    w_err_code_nxt = ERR_DISTURB;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and latched request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tgt   <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tgt   <= w_tgt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Registered outputs decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req.req_ready_o <= 1'b1;
            s_o             <= 1'b0;
            r_o             <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            err_code_o      <= ERR_NONE;
        end else begin
            req.req_ready_o <= (w_state_nxt == ST_IDLE);
            s_o             <= (w_state_nxt == ST_DRIVE) &&  w_tgt_nxt;
            r_o             <= (w_state_nxt == ST_DRIVE) && !w_tgt_nxt;
            busy_o          <= (w_state_nxt != ST_IDLE);
            done_o          <= (w_state_nxt == ST_DONE);
            err_o           <= (w_state_nxt == ST_ERR);
            err_code_o      <= w_err_code_nxt;
        end
    end

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver: a behavioural sr_ff closes the loop, and a
// stub q/qb source can override it to provoke the error paths.
module tb_sr_ff_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       q_i;
    logic       qb_i;
    logic       s_o;
    logic       r_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [1:0] err_code_o;

    logic       ff_q;
    logic       ff_load;
    logic       ff_load_val;
    logic       use_stub;
    logic       stub_q;
    logic       stub_qb;

    int n_checks = 0;
    int n_errors = 0;

    sr_ff_driver_if #(.HOLD_W(8)) req_if ();

    sr_ff_driver #(.HOLD_W(8), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req_if.slave),
        .q_i        (q_i),
        .qb_i       (qb_i),
        .s_o        (s_o),
        .r_o        (r_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    // Behavioural sr_ff with a preload port for setting up initial q.
    always @(posedge clk) begin
        if (ff_load)            ff_q <= ff_load_val;
        else if (s_o && !r_o)   ff_q <= 1'b1;
        else if (r_o && !s_o)   ff_q <= 1'b0;
        else                    ff_q <= ff_q;
    end

    assign q_i  = use_stub ? stub_q  : ff_q;
    assign qb_i = use_stub ? stub_qb : ~ff_q;

    // Output vector: {ready, s, r, busy, done, err, code[1:0]}
    function automatic logic [7:0] outs();
        return {req_if.req_ready_o, s_o, r_o, busy_o, done_o, err_o, err_code_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic val, input logic [7:0] hold);
        req_if.req_valid_i = 1'b1;
        req_if.req_val_i   = val;
        req_if.req_hold_i  = hold;
    endtask

    initial begin
        reset              = 1'b0;
        req_if.req_valid_i = 1'b0;
        req_if.req_val_i   = 1'b0;
        req_if.req_hold_i  = 8'd0;
        use_stub           = 1'b0;
        stub_q             = 1'b0;
        stub_qb            = 1'b1;
        ff_load            = 1'b1;
        ff_load_val        = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", outs(), 8'b1000_0000);
        reset   = 1'b1;
        ff_load = 1'b0;
        tick();
        check("idle after reset", outs(), 8'b1000_0000);
        check("ff preload 0", ff_q, 1'b0);

        // Set from cleared, hold=0
        request(1'b1, 8'd0);
        tick();
        check("set drive", outs(), 8'b0101_0000);
        req_if.req_valid_i = 1'b0;
        tick();
        check("set wait", outs(), 8'b0001_0000);
        check("set q", ff_q, 1'b1);
        tick();
        check("set done", outs(), 8'b0001_1000);
        tick();
        check("set idle", outs(), 8'b1000_0000);

        // Clear from set, hold=3; valid left high while busy must be ignored
        request(1'b0, 8'd3);
        tick();
        check("clr drive", outs(), 8'b0011_0000);
        req_if.req_val_i  = 1'b1;
        req_if.req_hold_i = 8'd0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("clr busy", outs(), 8'b0001_0000);
        end
        req_if.req_valid_i = 1'b0;
        tick();
        check("clr done", outs(), 8'b0001_1000);
        check("clr q", ff_q, 1'b0);
        tick();
        check("clr idle", outs(), 8'b1000_0000);

        // Already matched: q=1, set request, no pulse, done next cycle
        ff_load     = 1'b1;
        ff_load_val = 1'b1;
        tick();
        ff_load = 1'b0;
        check("ff preload 1", ff_q, 1'b1);
        request(1'b1, 8'd0);
        tick();
        check("match done", outs(), 8'b0001_1000);
        req_if.req_valid_i = 1'b0;
        tick();
        check("match idle", outs(), 8'b1000_0000);

        // Stuck feedback -> timeout
        use_stub = 1'b1;
        stub_q   = 1'b0;
        stub_qb  = 1'b1;
        request(1'b1, 8'd0);
        tick();
        check("to drive", outs(), 8'b0101_0000);
        req_if.req_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("to wait", outs(), 8'b0001_0000);
        end
        tick();
        check("to err", outs(), 8'b0001_0101);
        tick();
        check("to idle code held", outs(), 8'b1000_0001);

        // Illegal feedback q==qb in WAIT
        request(1'b1, 8'd0);
        tick();
        check("ill drive code clr", outs(), 8'b0101_0000);
        req_if.req_valid_i = 1'b0;
        tick();
        check("ill wait", outs(), 8'b0001_0000);
        stub_q  = 1'b1;
        stub_qb = 1'b1;
        tick();
        check("ill err", outs(), 8'b0001_0110);
        tick();
        check("ill idle code held", outs(), 8'b1000_0010);

        // Disturbed during HOLD
        stub_q  = 1'b1;
        stub_qb = 1'b0;
        request(1'b1, 8'd4);
        tick();
        check("dist hold1", outs(), 8'b0001_0000);
        req_if.req_valid_i = 1'b0;
        tick();
        check("dist hold2", outs(), 8'b0001_0000);
        stub_q  = 1'b0;
        stub_qb = 1'b1;
        tick();
        check("dist err", outs(), 8'b0001_0111);
        tick();
        check("dist idle code held", outs(), 8'b1000_0011);

        // Reset in DRIVE
        use_stub    = 1'b0;
        ff_load     = 1'b1;
        ff_load_val = 1'b0;
        tick();
        ff_load = 1'b0;
        request(1'b1, 8'd0);
        tick();
        check("rst drive", outs(), 8'b0101_0000);
        req_if.req_valid_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst async outs", outs(), 8'b1000_0000);
        tick();
        check("rst no set", ff_q, 1'b0);
        reset = 1'b1;
        tick();
        check("rst no done 1", outs(), 8'b1000_0000);
        tick();
        check("rst no done 2", outs(), 8'b1000_0000);

        // Normal request after reset release
        request(1'b1, 8'd0);
        tick();
        check("post drive", outs(), 8'b0101_0000);
        req_if.req_valid_i = 1'b0;
        tick();
        check("post wait", outs(), 8'b0001_0000);
        tick();
        check("post done", outs(), 8'b0001_1000);
        check("post q", ff_q, 1'b1);
        tick();
        check("post idle", outs(), 8'b1000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
